// File: rtl/fc_pkg.sv
// Shared definitions for the fc_layer pipeline: inter-layer link states and
// frame counter width.
package fc_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    ACK    = 2'd2,
    RUN    = 2'd3
  } link_state_t;

  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/fc_layer_link.sv
// Inter-layer link: loads the upstream activation stream into the downstream
// ibuf, launches the downstream layer, and back-pressures upstream while it runs.
module fc_layer_link
  import fc_pkg::*;
#(
  parameter int datatype_size = 8,
  parameter int vec_size      = 500,
  parameter int addr_width    = $clog2(vec_size)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [datatype_size-1:0] i_func_data,
  input  logic                     i_func_valid,
  output logic                     o_busy,
  output logic                     o_ibuf_we,
  output logic [datatype_size-1:0] o_ibuf_wr_data,
  output logic [addr_width-1:0]    o_ibuf_addr,
  output logic                     o_start,
  input  logic                     i_dst_busy,
  output logic                     o_overrun,
  output logic [FRAME_CNT_W-1:0]   o_frames
);

  localparam logic [addr_width-1:0] LAST_IDX = addr_width'(vec_size - 1);

  link_state_t              state_q, state_d;
  logic [addr_width-1:0]    cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     start_q, start_d;
  logic                     ovr_q, ovr_d;
  logic [FRAME_CNT_W-1:0]   frames_q, frames_d;
  logic                     vld_p0, vld_d;
  logic [datatype_size-1:0] wr_data_p0, wr_data_d;
  logic [addr_width-1:0]    addr_p0, addr_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    start_d   = 1'b0;
    ovr_d     = ovr_q;
    frames_d  = frames_q;
    vld_d     = 1'b0;
    wr_data_d = wr_data_p0;
    addr_d    = addr_p0;

    // Anything offered while busy is dropped; only the sticky flag records it.
    if (i_func_valid && busy_q) ovr_d = 1'b1;

    unique case (state_q)
      FILL: begin
        if (i_func_valid) begin
          vld_d     = 1'b1;
          wr_data_d = i_func_data;
          addr_d    = cnt_q;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = LAUNCH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LAUNCH: begin
        if (!i_dst_busy) begin
          start_d  = 1'b1;
          frames_d = frames_q + 1'b1;
          state_d  = ACK;
        end
      end
      ACK: begin
        // A busy that rises in the same cycle start is seen is still caught here.
        if (i_dst_busy) state_d = RUN;
      end
      RUN: begin
        if (!i_dst_busy) begin
          busy_d  = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Single registered stage: every output leaves a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      ovr_q      <= 1'b0;
      frames_q   <= '0;
      vld_p0     <= 1'b0;
      wr_data_p0 <= '0;
      addr_p0    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      ovr_q      <= ovr_d;
      frames_q   <= frames_d;
      vld_p0     <= vld_d;
      wr_data_p0 <= wr_data_d;
      addr_p0    <= addr_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_start        = start_q;
  assign o_overrun      = ovr_q;
  assign o_frames       = frames_q;
  assign o_ibuf_we      = vld_p0;
  assign o_ibuf_wr_data = wr_data_p0;
  assign o_ibuf_addr    = addr_p0;

endmodule

// File: tb/tb_fc_layer_link.sv
// Directed-plus-random bench for fc_layer_link against a cycle-level reference
// model of the load / launch / handshake protocol.
module tb_fc_layer_link;
  import fc_pkg::*;

  localparam int DW = 8;
  localparam int VS = 4;
  localparam int AW = $clog2(VS);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] func_data;
  logic          func_valid;
  logic          dst_busy;
  logic          busy, ibuf_we, start, overrun;
  logic [DW-1:0] ibuf_wr_data;
  logic [AW-1:0] ibuf_addr;
  logic [15:0]   frames;

  fc_layer_link #(.datatype_size(DW), .vec_size(VS)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_func_data   (func_data),
    .i_func_valid  (func_valid),
    .o_busy        (busy),
    .o_ibuf_we     (ibuf_we),
    .o_ibuf_wr_data(ibuf_wr_data),
    .o_ibuf_addr   (ibuf_addr),
    .o_start       (start),
    .i_dst_busy    (dst_busy),
    .o_overrun     (overrun),
    .o_frames      (frames)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what each output must read after the edge just taken.
  logic          m_busy, m_we, m_start, m_ovr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [15:0]   m_frames;
  int            m_idx;    // next element index within the vector being loaded
  int            m_phase;  // 0 vector waiting to launch, 1 awaiting downstream busy, 2 awaiting downstream done
  int            m_starts; // launches seen in the current scenario

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic db, input logic r);
    m_we    = 1'b0;
    m_start = 1'b0;
    if (r) begin
      m_busy = 0; m_ovr = 0; m_addr = '0; m_data = '0;
      m_frames = '0; m_idx = 0; m_phase = 0;
    end else if (!m_busy) begin
      if (v) begin
        m_we   = 1'b1;
        m_addr = AW'(m_idx);
        m_data = d;
        m_idx  = m_idx + 1;
        if (m_idx == VS) begin
          m_idx   = 0;
          m_busy  = 1'b1;
          m_phase = 0;
        end
      end
    end else begin
      if (v) m_ovr = 1'b1;
      if (m_phase == 0 && !db) begin
        m_start  = 1'b1;
        m_frames = m_frames + 16'd1;
        m_starts++;
        m_phase  = 1;
      end else if (m_phase == 1 && db) begin
        m_phase = 2;
      end else if (m_phase == 2 && !db) begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic db, input logic r);
    func_valid = v;
    func_data  = d;
    dst_busy   = db;
    rst        = r;
    @(posedge clk);
    #1;
    model_step(v, d, db, r);
    chk("busy",    32'(busy),         32'(m_busy));
    chk("we",      32'(ibuf_we),      32'(m_we));
    chk("addr",    32'(ibuf_addr),    32'(m_addr));
    chk("data",    32'(ibuf_wr_data), 32'(m_data));
    chk("start",   32'(start),        32'(m_start));
    chk("overrun", 32'(overrun),      32'(m_ovr));
    chk("frames",  32'(frames),       32'(m_frames));
  endtask

  task automatic send_vec(input int gap_max, input logic db);
    for (int i = 0; i < VS; i++) begin
      repeat ($urandom_range(gap_max, 0)) cyc(1'b0, DW'($urandom), db, 1'b0);
      cyc(1'b1, DW'($urandom), db, 1'b0);
    end
  endtask

  task automatic handshake(input int block, input int ack_wait, input int pulse);
    repeat (block) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (ack_wait) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (pulse) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    m_starts = 0;
    model_step(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset state
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Basic vector: back-to-back 0x11..0x44, immediate launch and 1-cycle busy
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    handshake(0, 0, 1);
    chk("basic_frames", 32'(frames), 32'd1);

    // Blocked start: downstream busy for 10 cycles after completion
    send_vec(1, 1'b1);
    handshake(10, 2, 3);

    // Overrun during RUN, then the next vector restarts at address 0
    send_vec(0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    send_vec(0, 1'b0);
    handshake(0, 0, 1);

    // Gapped input: three idle cycles between elements, exactly one start
    m_starts = 0;
    for (int i = 0; i < VS; i++) begin
      repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b1, DW'($urandom), 1'b0, 1'b0);
    end
    handshake(0, 1, 2);
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("gap_one_start", 32'(m_starts), 32'd1);

    // Reset mid-vector, then a fresh 0xA0..0xA3 vector
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < VS; i++) cyc(1'b1, 8'hA0 + DW'(i), 1'b0, 1'b0);
    handshake(0, 0, 1);
    chk("rst_frames", 32'(frames), 32'd1);

    // Frame counter wrap from a backdoor preload of 0xFFFF
    force dut.frames_q = 16'hFFFF;
    #1;
    release dut.frames_q;
    m_frames = 16'hFFFF;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    send_vec(0, 1'b0);
    handshake(0, 0, 1);
    chk("wrap_frames", 32'(frames), 32'd0);

    // Random traffic: gaps, blocking, acknowledgement delays
    for (int n = 0; n < 12; n++) begin
      send_vec(2, 1'($urandom));
      handshake($urandom_range(4, 0), $urandom_range(3, 0), $urandom_range(3, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
